// File: rtl/div_if.sv
// Handshake and data bundle between the EX stage and the multi-cycle divider.
interface div_if #(
    parameter int WIDTH = 32
);
    logic               start_in;
    logic               annul_in;
    logic               signed_div_in;
    logic [WIDTH-1:0]   opdata1_in;
    logic [WIDTH-1:0]   opdata2_in;
    logic [2*WIDTH-1:0] result_out;
    logic               ready_out;
    logic               busy_out;

    // EX stage side: issues requests, consumes results
    modport master (
        output start_in, annul_in, signed_div_in, opdata1_in, opdata2_in,
        input  result_out, ready_out, busy_out
    );

    // Divider side
    modport slave (
        input  start_in, annul_in, signed_div_in, opdata1_in, opdata2_in,
        output result_out, ready_out, busy_out
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU. One quotient bit per cycle,
// operands handled as magnitudes with the signs reapplied on the last edge.
// Result layout is {remainder, quotient}.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        BY_ZERO = 2'd1,
        ON      = 2'd2,
        END     = 2'd3
    } state_t;

    // Two's-complement magnitude of a value when it is to be read as negative
    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // Conditional negation used for the final sign correction
    function automatic logic [WIDTH-1:0] f_apply_sign(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_quo;       // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH:0]     r_rem;       // one guard bit so the trial subtract sign is visible
    logic               r_neg_q;
    logic               r_neg_r;
    logic [2*WIDTH-1:0] r_result;
    logic               r_ready;

    logic               w_load;
    logic               w_iter;
    logic               w_ready_nxt;
    logic [2*WIDTH-1:0] w_result_nxt;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_qbit;
    logic [WIDTH:0]     w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic [2*WIDTH-1:0] w_final;

    assign w_a_neg = bus.signed_div_in & bus.opdata1_in[WIDTH-1];
    assign w_b_neg = bus.signed_div_in & bus.opdata2_in[WIDTH-1];

    // Restoring step: bring down the next dividend bit, trial-subtract, keep or restore
    assign w_shift   = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, r_divisor};
    assign w_qbit    = ~w_diff[WIDTH];
    assign w_rem_nxt = w_qbit ? w_diff : w_shift;
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_qbit};

    // Most-negative / -1 needs no special case: the magnitude quotient wraps to itself
    assign w_final = {f_apply_sign(w_rem_nxt[WIDTH-1:0], r_neg_r),
                      f_apply_sign(w_quo_nxt, r_neg_q)};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FREE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, datapath strobes and next output values; annul wins everywhere
    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_iter       = 1'b0;
        w_ready_nxt  = 1'b0;
        w_result_nxt = '0;
        case (r_state)
            FREE: begin
                if (!bus.annul_in && bus.start_in) begin
                    if (bus.opdata2_in == '0) begin
                        w_state_nxt = BY_ZERO;
                    end else begin
                        w_state_nxt = ON;
                        w_load      = 1'b1;
                    end
                end
            end
            BY_ZERO: begin
                if (bus.annul_in) begin
                    w_state_nxt = FREE;
                end else begin
                    w_state_nxt = END;
                    w_ready_nxt = 1'b1;
                end
            end
            ON: begin
                if (bus.annul_in) begin
                    w_state_nxt = FREE;
                end else begin
                    w_iter = 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        w_state_nxt  = END;
                        w_ready_nxt  = 1'b1;
                        w_result_nxt = w_final;
                    end
                end
            end
            END: begin
                if (bus.annul_in || !bus.start_in) begin
                    w_state_nxt = FREE;
                end else begin
                    w_ready_nxt  = 1'b1;
                    w_result_nxt = r_result;
                end
            end
            default: w_state_nxt = FREE;
        endcase
    end

    // Operand latch and per-cycle iteration of the divide datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_rem     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else if (w_load) begin
            r_cnt     <= '0;
            r_quo     <= f_mag(bus.opdata1_in, w_a_neg);
            r_divisor <= f_mag(bus.opdata2_in, w_b_neg);
            r_rem     <= '0;
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
        end else if (w_iter) begin
            r_cnt <= r_cnt + 1'b1;
            r_quo <= w_quo_nxt;
            r_rem <= w_rem_nxt;
        end
    end

    // Registered result and ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_ready  <= 1'b0;
        end else begin
            r_result <= w_result_nxt;
            r_ready  <= w_ready_nxt;
        end
    end

    assign bus.result_out = r_result;
    assign bus.ready_out  = r_ready;
    assign bus.busy_out   = (r_state == BY_ZERO) || (r_state == ON);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: a 32-bit and an 8-bit instance share the
// stimulus, one is selected per operation, and every result is compared with
// an arithmetic reference model.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        tb_sel;      // 0 = 32-bit instance, 1 = 8-bit instance
    logic        tb_start;
    logic        tb_annul;
    logic        tb_s;
    logic [31:0] tb_a;
    logic [31:0] tb_b;

    int n_chk;
    int n_fail;

    div_if #(.WIDTH(32)) if32 ();
    div_if #(.WIDTH(8))  if8  ();

    div_unit #(.WIDTH(32), .CNT_W(6)) u_dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
    div_unit #(.WIDTH(8),  .CNT_W(4)) u_dut8  (.clk(clk), .rst(rst), .bus(if8.slave));

    assign if32.start_in      = tb_start & ~tb_sel;
    assign if32.annul_in      = tb_annul;
    assign if32.signed_div_in = tb_s;
    assign if32.opdata1_in    = tb_a;
    assign if32.opdata2_in    = tb_b;
    assign if8.start_in       = tb_start & tb_sel;
    assign if8.annul_in       = tb_annul;
    assign if8.signed_div_in  = tb_s;
    assign if8.opdata1_in     = tb_a[7:0];
    assign if8.opdata2_in     = tb_b[7:0];

    logic [63:0] obs_result;
    logic        obs_ready;
    logic        obs_busy;
    assign obs_result = tb_sel ? 64'(if8.result_out) : if32.result_out;
    assign obs_ready  = tb_sel ? if8.ready_out : if32.ready_out;
    assign obs_busy   = tb_sel ? if8.busy_out  : if32.busy_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {remainder, quotient} from plain integer division on w-bit operands
    function automatic logic [63:0] model(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic s);
        longint m, sa, sb, q, r;
        m  = (longint'(1) << w) - 1;
        sa = longint'(a) & m;
        sb = longint'(b) & m;
        if (sb == 0) return 64'd0;
        if (s) begin
            if (sa[w-1]) sa = sa - (longint'(1) << w);
            if (sb[w-1]) sb = sb - (longint'(1) << w);
        end
        q = sa / sb;
        r = sa % sb;
        return 64'(((r & m) << w) | (q & m));
    endfunction

    // Full transaction: accept, wait for ready, check latency/result, hold, release
    task automatic run_op(input logic sel, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input string tag);
        int          w;
        int          lat;
        logic [63:0] exp;
        logic [31:0] bm;
        w   = sel ? 8 : 32;
        bm  = sel ? (b & 32'hFF) : b;
        exp = model(w, a, b, s);
        tb_sel   = sel;
        tb_a     = a;
        tb_b     = b;
        tb_s     = s;
        tb_start = 1'b1;
        tick();
        check({tag, "_busy"}, 64'(obs_busy), 64'd1);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (obs_ready) begin
                lat = k;
                break;
            end
        end
        check({tag, "_lat"}, 64'(lat), (bm == 0) ? 64'd1 : 64'(w));
        check({tag, "_res"}, obs_result, exp);
        check({tag, "_idle"}, 64'(obs_busy), 64'd0);
        tick();
        check({tag, "_hold"}, {obs_result[62:0], obs_ready}, {exp[62:0], 1'b1});
        tb_start = 1'b0;
        tick();
        check({tag, "_clr"}, {obs_result[62:0], obs_ready}, 64'd0);
        tick();
    endtask

    initial begin
        int          cnt;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic        rsel;
        n_chk    = 0;
        n_fail   = 0;
        tb_sel   = 1'b0;
        tb_start = 1'b0;
        tb_annul = 1'b0;
        tb_s     = 1'b0;
        tb_a     = '0;
        tb_b     = '0;
        rst      = 1'b1;
        #12;
        check("rst32", {if32.result_out[62:0], if32.ready_out}, 64'd0);
        check("rst32_busy", 64'(if32.busy_out), 64'd0);
        check("rst8", {47'd0, if8.result_out, if8.ready_out, if8.busy_out}, 64'd0);
        rst = 1'b0;
        tick();

        // Directed vectors
        run_op(1'b0, 32'd7, 32'd2, 1'b0, "u7_2");
        run_op(1'b0, 32'hFFFFFFF9, 32'd2, 1'b1, "sm7_2");
        run_op(1'b0, 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, "sm7_m2");
        run_op(1'b0, 32'd123, 32'd0, 1'b0, "div0");
        run_op(1'b0, 32'h80000000, 32'hFFFFFFFF, 1'b1, "minneg");
        run_op(1'b0, 32'hFFFFFFFF, 32'd1, 1'b0, "umax");
        run_op(1'b1, 32'd200, 32'd7, 1'b0, "u8_200_7");
        run_op(1'b1, 32'h80, 32'hFF, 1'b1, "s8_minneg");
        run_op(1'b1, 32'h55, 32'h00, 1'b1, "s8_div0");

        // Annul in ON at iteration 10
        tb_sel = 1'b0; tb_a = 32'd100; tb_b = 32'd3; tb_s = 1'b0;
        tb_start = 1'b1;
        tick();
        for (int k = 0; k < 9; k++) tick();
        tb_annul = 1'b1;
        tb_start = 1'b0;
        tick();
        tb_annul = 1'b0;
        check("annul_state", {obs_result[61:0], obs_ready, obs_busy}, 64'd0);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (obs_ready) cnt++;
        end
        check("annul_noready", 64'(cnt), 64'd0);
        run_op(1'b0, 32'd100, 32'd3, 1'b0, "post_annul");

        // Annul in BY_ZERO
        tb_a = 32'd5; tb_b = 32'd0; tb_start = 1'b1;
        tick();
        tb_annul = 1'b1;
        tb_start = 1'b0;
        tick();
        tb_annul = 1'b0;
        check("annul_bz", {obs_result[61:0], obs_ready, obs_busy}, 64'd0);
        tick();

        // Asynchronous reset at iteration 5
        tb_a = 32'd1000; tb_b = 32'd7; tb_start = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) tick();
        tb_start = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_out", {obs_result[61:0], obs_ready, obs_busy}, 64'd0);
        rst = 1'b0;
        tick();
        run_op(1'b0, 32'd9, 32'd4, 1'b0, "post_rst");

        // Randomized operations on both instances
        for (int i = 0; i < 24; i++) begin
            rsel = 1'($urandom_range(0, 1));
            rs   = 1'($urandom_range(0, 1));
            ra   = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            if (rsel && rb[7:0] == 8'd0 && $urandom_range(0, 1) == 1) rb[0] = 1'b1;
            run_op(rsel, ra, rb, rs, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Parametrised multi-cycle restoring divider for the 5-stage MIPS pipeline, serving DIV/DIVU.
- Sits beside the EX stage. EX asserts start_in and holds the pipeline stalled (via busy_out) until ready_out.
- Generalised over the single-cycle ALU path:
  - WIDTH is configurable.
  - Signed and unsigned modes are selected per operation.
  - Divide-by-zero takes a short path.
  - An in-flight divide can be cancelled with annul_in on a flush.

Parameters:
- WIDTH, 32, operand width in bits; must be >= 4.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_in  input  1  request a divide; sampled only in FREE.
- annul_in  input  1  cancel current operation (pipeline flush).
- signed_div_in  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_in.
- opdata1_in  input  WIDTH  dividend; sampled with start_in.
- opdata2_in  input  WIDTH  divisor; sampled with start_in.
- result_out  output  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}.
- ready_out  output  1  result_out valid.
- busy_out  output  1  operation in progress; EX uses it as stall request.

Behaviour:
- Reset (async, rst=1): state=FREE, counter=0, result_out=0, ready_out=0, busy_out=0, internal dividend/divisor registers=0.
- States: FREE, BY_ZERO, ON, END (2-bit, registered). busy_out=1 exactly in BY_ZERO and ON. ready_out and result_out are registered.
- FREE:
  - annul_in=1: stay FREE. annul has priority over start.
  - start_in=1, divisor==0: go to BY_ZERO.
  - start_in=1, divisor!=0: latch operands and go to ON with counter=0.
  - In signed mode, a negative operand is latched as its two's-complement magnitude. The original signs are stored.
  - ready_out=0, result_out=0.
- BY_ZERO: next edge goes to END with result_out=0 and ready_out=1. annul_in=1 goes to FREE instead.
- ON:
  - One restoring iteration per cycle on a (WIDTH+1)-bit partial remainder: shift in the next dividend bit; subtract the divisor; if the result is non-negative, keep it and shift 1 into the quotient, else restore and shift 0.
  - The counter increments each cycle.
  - At the edge completing iteration WIDTH: go to END, ready_out=1, result_out loaded with the sign-corrected result.
  - annul_in=1 in any ON cycle: go to FREE next edge, ready_out=0, result_out=0, no partial result exposed.
  - start_in changes are ignored.
- Sign correction (signed mode only):
  - Quotient is negated iff the dividend and divisor signs differ.
  - Remainder takes the sign of the dividend.
  - Most-negative dividend / -1 yields quotient = most-negative value (wraps), remainder 0.
- END:
  - ready_out=1 and result_out held while start_in=1 (EX holds start_in until it consumes the result).
  - start_in=0 or annul_in=1: go to FREE next edge, clearing ready_out and result_out.
- Latency:
  - Nonzero divisor: ready_out rises WIDTH cycles after the start-accepting edge, i.e. at the WIDTH-th edge following it.
  - Zero divisor: ready_out rises 1 cycle after the start-accepting edge.
- Back-to-back operations: a new start is accepted only in FREE. The minimum gap is one FREE cycle after END.
- Reset mid-operation: immediate return to reset values; no result is produced.

Test Plan:
- Unsigned, WIDTH=32: opdata1=7, opdata2=2, signed=0, start held -> busy_out for 32 cycles; ready_out=1 at the 32nd edge after acceptance; result_out = {32'h1, 32'h3}.
- Signed, WIDTH=32: opdata1=32'hFFFFFFF9 (-7), opdata2=2 -> result_out = {32'hFFFFFFFF, 32'hFFFFFFFD}; repeat with -7/-2 -> {32'hFFFFFFFF, 32'h3}.
- Divide by zero: opdata1=123, opdata2=0 -> BY_ZERO for one cycle, ready_out=1 at the next edge, result_out=0; drop start_in -> ready_out=0 next edge.
- Annul: start 100/3, assert annul_in for one cycle at iteration 10 -> FREE next edge, ready_out never asserts, result_out=0; a fresh start 100/3 then returns {1, 33}.
- Async reset mid-ON: pulse rst between edges at iteration 5 -> all outputs 0 immediately; after release, 9/4 completes with {1, 2}.
- WIDTH=8 instance: unsigned 200/7 -> {8'd4, 8'd28} at the 8th edge; signed 8'h80/8'hFF -> {8'h00, 8'h80}.
